// File: rtl/motor_ramp_ctrl.sv
// motor_ramp_ctrl: per-wheel duty sequencer feeding one 10-bit PWM channel.
// Slews the duty magnitude toward a signed speed target at a fixed rate.
// Ramps to zero and waits a dead time before any direction change.
// Brake overrides everything and drives duty 0, which the PWM treats as brake.
module motor_ramp_ctrl #(
  parameter int RAMP_DIV   = 1024,
  parameter int STEP       = 8,
  parameter int DEAD_TICKS = 4,
  parameter int MIN_DUTY   = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_vld,
  input  logic signed [10:0] cmd_spd,
  output logic               cmd_rdy,
  input  logic               brake,
  output logic [9:0]         duty,
  output logic               fwd,
  output logic               at_target
);

  localparam int PW = $clog2(RAMP_DIV);
  localparam int DW = $clog2(DEAD_TICKS + 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(RAMP_DIV - 1);
  localparam logic [DW-1:0] DEAD_INIT  = DW'(DEAD_TICKS);
  localparam logic [9:0]    STEP_V     = 10'(STEP);
  localparam logic [9:0]    MIN_V      = 10'(MIN_DUTY);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RAMP,
    S_DEAD,
    S_BRAKE
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [9:0]      cur_mag_q, cur_mag_d;
  logic [9:0]      tgt_mag_q, tgt_mag_d;
  logic            tgt_dir_q, tgt_dir_d;
  logic            dir_q, dir_d;
  logic [DW-1:0]   dead_cnt_q, dead_cnt_d;
  logic [9:0]      duty_q, duty_d;
  logic            fwd_q, fwd_d;
  logic            at_target_q, at_target_d;

  logic            tick;
  logic            acc;
  logic [9:0]      new_mag;
  logic            new_dir;
  logic [9:0]      nxt_mag;

  // Magnitude of a signed speed; -1024 has no 10-bit magnitude and saturates to 1023.
  function automatic logic [9:0] sat_mag(input logic signed [10:0] spd);
    logic signed [11:0] wide;
    wide = spd;
    if (spd[10]) wide = -wide;
    if (wide > 12'sd1023) return 10'd1023;
    return wide[9:0];
  endfunction

  // One slew step toward tgt, clamped so the ramp never overshoots.
  function automatic logic [9:0] step_toward(input logic [9:0] cur, input logic [9:0] tgt);
    logic [9:0] diff;
    if (cur < tgt) begin
      diff = tgt - cur;
      return (diff > STEP_V) ? (cur + STEP_V) : tgt;
    end
    diff = cur - tgt;
    return (diff > STEP_V) ? (cur - STEP_V) : tgt;
  endfunction

  // One slew step toward zero, floored at zero.
  function automatic logic [9:0] step_down(input logic [9:0] cur);
    return (cur > STEP_V) ? (cur - STEP_V) : 10'd0;
  endfunction

  assign tick      = (presc_q == PRESC_LAST);
  assign cmd_rdy   = (state_q == S_IDLE) || (state_q == S_RAMP);
  assign acc       = cmd_vld && cmd_rdy && !brake;
  assign new_mag   = sat_mag(cmd_spd);
  assign new_dir   = (cmd_spd == 11'sd0) ? tgt_dir_q : !cmd_spd[10];
  assign duty      = duty_q;
  assign fwd       = fwd_q;
  assign at_target = at_target_q;

  // Free-running ramp prescaler; only reset clears it.
  always_comb begin
    presc_d = tick ? '0 : presc_q + 1'b1;
  end

  // Next-state, target latch and slew arithmetic.
  always_comb begin
    state_d    = state_q;
    cur_mag_d  = cur_mag_q;
    tgt_mag_d  = tgt_mag_q;
    tgt_dir_d  = tgt_dir_q;
    dir_d      = dir_q;
    dead_cnt_d = dead_cnt_q;
    nxt_mag    = cur_mag_q;

    if (acc) begin
      tgt_mag_d = new_mag;
      tgt_dir_d = new_dir;
    end

    if (brake) begin
      state_d   = S_BRAKE;
      cur_mag_d = 10'd0;
      tgt_mag_d = 10'd0;
      // Keep target direction aligned with the bridge so a later zero command does not reverse.
      tgt_dir_d = dir_q;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (acc && ((new_mag != cur_mag_q) || (new_dir != dir_q))) state_d = S_RAMP;
        end
        S_RAMP: begin
          if (tgt_dir_q != dir_q) begin
            if (cur_mag_q == 10'd0) begin
              state_d    = S_DEAD;
              dead_cnt_d = DEAD_INIT;
            end else if (tick) begin
              nxt_mag   = step_down(cur_mag_q);
              cur_mag_d = nxt_mag;
              if (nxt_mag == 10'd0) begin
                state_d    = S_DEAD;
                dead_cnt_d = DEAD_INIT;
              end
            end
          end else if (tick) begin
            // This tick steps toward the old target; a target latched now keeps us ramping.
            nxt_mag   = step_toward(cur_mag_q, tgt_mag_q);
            cur_mag_d = nxt_mag;
            if ((nxt_mag == tgt_mag_q) && !acc) state_d = S_IDLE;
          end
        end
        S_DEAD: begin
          if (tick) begin
            if (dead_cnt_q <= DW'(1)) begin
              dead_cnt_d = '0;
              dir_d      = tgt_dir_q;
              state_d    = (tgt_mag_q == 10'd0) ? S_IDLE : S_RAMP;
            end else begin
              dead_cnt_d = dead_cnt_q - 1'b1;
            end
          end
        end
        S_BRAKE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // Output stage: duty and direction trail the internal magnitude by one clock; brake acts at once.
  always_comb begin
    duty_d      = (state_d == S_BRAKE) ? 10'd0 :
                  ((cur_mag_q == 10'd0) ? MIN_V : cur_mag_q);
    fwd_d       = dir_q;
    at_target_d = (state_q == S_IDLE);
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      presc_q     <= '0;
      cur_mag_q   <= 10'd0;
      tgt_mag_q   <= 10'd0;
      tgt_dir_q   <= 1'b1;
      dir_q       <= 1'b1;
      dead_cnt_q  <= '0;
      duty_q      <= MIN_V;
      fwd_q       <= 1'b1;
      at_target_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      cur_mag_q   <= cur_mag_d;
      tgt_mag_q   <= tgt_mag_d;
      tgt_dir_q   <= tgt_dir_d;
      dir_q       <= dir_d;
      dead_cnt_q  <= dead_cnt_d;
      duty_q      <= duty_d;
      fwd_q       <= fwd_d;
      at_target_q <= at_target_d;
    end
  end

endmodule
